// File: rtl/acc_flags_stage_pkg.sv
// Shared definitions for the accumulator/flag stage that sits downstream of the 4-bit ALU:
// default widths, the output-register state encoding and the reset values.
package acc_flags_stage_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int   ACC_RST_VAL = 0;
  localparam int   CNT_RST_VAL = 0;
  localparam logic FLAG_RST    = 1'b0;

endpackage

// File: rtl/acc_flags_skid_reg.sv
// One-entry valid/ready pipeline register. It accepts a new word in the same cycle that the
// held word drains, so it sustains one transfer per cycle.
module acc_flags_skid_reg
  import acc_flags_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  state_t            state_p1;
  logic [DATA_W-1:0] data_p1;
  logic              accept;

  // in_ready depends only on held state and out_ready, never on in_valid
  assign in_ready  = (state_p1 == EMPTY) | out_ready;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_p1 == FULL);
  assign out_data  = data_p1;

  // stage p1: held output word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1 <= EMPTY;
      data_p1  <= DATA_W'(ACC_RST_VAL);
    end else begin
      case (state_p1)
        EMPTY: begin
          if (accept) begin
            state_p1 <= FULL;
            data_p1  <= in_data;
          end
        end
        FULL: begin
          if (accept) begin
            data_p1 <= in_data;
          end else if (out_ready) begin
            state_p1 <= EMPTY;
          end
        end
        default: state_p1 <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/acc_flags_stage.sv
// Accumulator, carry/zero flag register and transfer counter behind the ALU, with results
// forwarded through a one-entry output register. Optional macro: STICKY_CARRY_EN.
module acc_flags_stage
  import acc_flags_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_acc,
  input  logic              load_flags,
  input  logic              flags_clr,
  output logic [DATA_W-1:0] acc,
  output logic              c_flag,
  output logic              z_flag,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  xfer_cnt
);

  logic accept;

  // Carry update on a flag load; the sticky build ORs into the held carry.
  function automatic logic next_carry(input logic held, input logic presented);
`ifdef STICKY_CARRY_EN
    return held | presented;
`else
    return presented | (held & 1'b0);
`endif
  endfunction

  assign accept = in_valid & in_ready;

  acc_flags_skid_reg #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_data  (alu_out),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // stage p1: accumulator, flags and counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= DATA_W'(ACC_RST_VAL);
      c_flag   <= FLAG_RST;
      z_flag   <= FLAG_RST;
      xfer_cnt <= CNT_W'(CNT_RST_VAL);
    end else begin
      if (accept) begin
        xfer_cnt <= xfer_cnt + CNT_W'(1);
        if (load_acc)
          acc <= alu_out;
      end
      // a clear beats a simultaneous flag load
      if (flags_clr) begin
        c_flag <= 1'b0;
        z_flag <= 1'b0;
      end else if (accept && load_flags) begin
        c_flag <= next_carry(c_flag, alu_carry);
        z_flag <= alu_zero;
      end
    end
  end

endmodule

// File: tb/tb_acc_flags_stage.sv
// Directed self-checking bench for acc_flags_stage; expected values are hand-computed.
module tb_acc_flags_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] alu_out;
  logic       alu_carry, alu_zero;
  logic       in_valid, in_ready;
  logic       load_acc, load_flags, flags_clr;
  logic [3:0] acc;
  logic       c_flag, z_flag;
  logic [3:0] out_data;
  logic       out_valid, out_ready;
  logic [7:0] xfer_cnt;

  int checks = 0;
  int failures = 0;

  acc_flags_stage dut (
    .clk       (clk),
    .reset     (reset),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .alu_zero  (alu_zero),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .load_acc  (load_acc),
    .load_flags(load_flags),
    .flags_clr (flags_clr),
    .acc       (acc),
    .c_flag    (c_flag),
    .z_flag    (z_flag),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic c, input logic z,
                       input logic la, input logic lf);
    in_valid = v; alu_out = d; alu_carry = c; alu_zero = z; load_acc = la; load_flags = lf;
  endtask

  logic [7:0] exp_c [3];

  initial begin
    reset = 1'b1; flags_clr = 1'b0; out_ready = 1'b1;
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_acc", 8'(acc), 8'h0);
    chk("rst_flags", {6'd0, c_flag, z_flag}, 8'h0);
    chk("rst_out_valid", 8'(out_valid), 8'h0);
    chk("rst_cnt", xfer_cnt, 8'h0);
    chk("rst_in_ready", 8'(in_ready), 8'h1);

    // basic capture
    drive(1'b1, 4'hA, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("cap_acc", 8'(acc), 8'hA);
    chk("cap_c", 8'(c_flag), 8'h1);
    chk("cap_z", 8'(z_flag), 8'h0);
    chk("cap_out", 8'(out_data), 8'hA);
    chk("cap_vld", 8'(out_valid), 8'h1);
    chk("cap_cnt", xfer_cnt, 8'h1);

    // backpressure: A drains as 3 enters, then 5 waits behind a stalled 3
    drive(1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("bp_out3", 8'(out_data), 8'h3);
    out_ready = 1'b0;
    drive(1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("bp_in_ready0", 8'(in_ready), 8'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_out", 8'(out_data), 8'h3);
      chk("bp_hold_vld", 8'(out_valid), 8'h1);
      chk("bp_hold_rdy", 8'(in_ready), 8'h0);
      chk("bp_hold_acc", 8'(acc), 8'h3);
      chk("bp_hold_cnt", xfer_cnt, 8'h2);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready1", 8'(in_ready), 8'h1);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_out5", 8'(out_data), 8'h5);
    chk("bp_acc5", 8'(acc), 8'h5);
    chk("bp_cnt", xfer_cnt, 8'h3);
    step();
    chk("bp_drain_vld", 8'(out_valid), 8'h0);

    // qualifiers and flag clear
    drive(1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("q_acc_hold", 8'(acc), 8'h5);
    chk("q_flags", {6'd0, c_flag, z_flag}, 8'h1);
    chk("q_out", 8'(out_data), 8'hF);
    flags_clr = 1'b1;
    drive(1'b1, 4'h7, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    flags_clr = 1'b0;
    drive(1'b0, 4'h2, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_flags", {6'd0, c_flag, z_flag}, 8'h0);
    chk("clr_acc", 8'(acc), 8'h7);
    chk("clr_cnt", xfer_cnt, 8'h5);
    step();
    chk("noacc_acc", 8'(acc), 8'h7);
    chk("noacc_flags", {6'd0, c_flag, z_flag}, 8'h0);
    chk("noacc_cnt", xfer_cnt, 8'h5);

    // carry sequence 1,0,0
`ifdef STICKY_CARRY_EN
    exp_c[0] = 8'h1; exp_c[1] = 8'h1; exp_c[2] = 8'h1;
`else
    exp_c[0] = 8'h1; exp_c[1] = 8'h0; exp_c[2] = 8'h0;
`endif
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'h1, (i == 0), 1'b0, 1'b0, 1'b1);
      step();
      chk("carry_seq", 8'(c_flag), exp_c[i]);
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    flags_clr = 1'b1;
    step();
    flags_clr = 1'b0;
    chk("carry_clr", 8'(c_flag), 8'h0);

    // asynchronous reset with a pending output
    drive(1'b1, 4'h9, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_vld", 8'(out_valid), 8'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_acc", 8'(acc), 8'h0);
    chk("arst_flags", {6'd0, c_flag, z_flag}, 8'h0);
    chk("arst_out", 8'(out_data), 8'h0);
    chk("arst_vld", 8'(out_valid), 8'h0);
    chk("arst_cnt", xfer_cnt, 8'h0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_vld", 8'(out_valid), 8'h0);

    // 256 back-to-back transfers: ordered data and counter wrap
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 4'(i), 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      chk("wrap_data", 8'(out_data), 8'(i % 16));
      if (i == 254) chk("wrap_cnt_ff", xfer_cnt, 8'hFF);
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_cnt_zero", xfer_cnt, 8'h0);
    chk("wrap_vld", 8'(out_valid), 8'h1);
    step();
    chk("wrap_drain", 8'(out_valid), 8'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
